// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: pops words from a fifo_sync read port and
// streams them out as SLICE_WIDTH slices, least-significant first.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   en                 run enable; gates new FIFO pops only
//   fifo_cs            FIFO chip select (!rst)
//   fifo_rd_en         FIFO pop request (Mealy)
//   fifo_data_out      FIFO read data, valid one cycle after pop
//   fifo_empty         FIFO empty flag
//   out_valid/ready    slice stream handshake
//   out_data           current slice
//   out_last           final slice of a word
//   busy               FSM not idle
//   word_count         words fully transmitted (wraps)
module fifo_word_serializer #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int SLICE_WIDTH = 8,
  localparam int NUM_SLICES  = DATA_WIDTH / SLICE_WIDTH,
  localparam int CNT_W       = (NUM_SLICES > 1) ?
                               $clog2(NUM_SLICES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   fifo_cs,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_data_out,
  input  logic                   fifo_empty,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [15:0]            word_count
);

  if ((SLICE_WIDTH < 1) ||
      ((DATA_WIDTH % SLICE_WIDTH) != 0)) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of SLICE_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(NUM_SLICES - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] sreg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  pop_ok;
  logic                  last_slice;
  logic                  hs;

  assign fifo_cs    = !rst;
  assign pop_ok     = en && !fifo_empty;
  assign last_slice = (cnt_q == LAST_IDX);
  assign hs         = out_valid && out_ready;
  assign cnt_nxt    = cnt_q + 1'b1;
  assign out_data   = sreg_q[SLICE_WIDTH-1:0];

  // Pop decision is combinational so a new word can be
  // requested on the same edge the last slice is accepted.
  always_comb begin
    fifo_rd_en = 1'b0;
    unique case (state_q)
      IDLE:    fifo_rd_en = pop_ok;
      SEND:    fifo_rd_en = hs && last_slice && pop_ok;
      default: fifo_rd_en = 1'b0;
    endcase
    if (rst) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fifo_rd_en) begin
            state_q <= WAIT;
            busy    <= 1'b1;
          end
        end
        WAIT: begin
          sreg_q    <= fifo_data_out;
          cnt_q     <= '0;
          state_q   <= SEND;
          out_valid <= 1'b1;
          out_last  <= (NUM_SLICES == 1);
        end
        SEND: begin
          if (out_ready) begin
            if (last_slice) begin
              word_count <= word_count + 16'd1;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              if (fifo_rd_en) begin
                state_q <= WAIT;
              end else begin
                state_q <= IDLE;
                busy    <= 1'b0;
              end
            end else begin
              sreg_q   <= sreg_q >> SLICE_WIDTH;
              cnt_q    <= cnt_nxt;
              out_last <= (cnt_nxt == LAST_IDX);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Downstream consumer of fifo_sync: pops DATA_WIDTH-bit words from the FIFO read port and emits each word as NUM_SLICES slices of SLICE_WIDTH bits, least-significant slice first.
- Output is a valid/ready stream toward narrower links such as a byte-wide UART/SPI transmitter.
- Handles the FIFO's one-cycle read latency, downstream backpressure and end-of-word marking.

Parameters:
- DATA_WIDTH, 32, FIFO word width; must equal the FIFO DATA_WIDTH.
- SLICE_WIDTH, 8, output slice width; DATA_WIDTH must be an integer multiple of it (elaboration error otherwise).
- NUM_SLICES, DATA_WIDTH/SLICE_WIDTH, derived; not to be overridden.
- CNT_W, clog2(NUM_SLICES) (min 1), slice counter width, derived.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; when low, no new FIFO read is started.
- fifo_cs  output  1  FIFO chip select; high whenever rst is low.
- fifo_rd_en  output  1  FIFO pop request, one cycle per word.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en is sampled.
- fifo_empty  input  1  FIFO empty flag.
- out_valid  output  1  out_data holds a valid slice.
- out_ready  input  1  downstream accepts the slice when out_valid && out_ready.
- out_data  output  SLICE_WIDTH  current slice.
- out_last  output  1  high with the final slice of each word.
- busy  output  1  high in any state other than IDLE.
- word_count  output  16  count of words fully transmitted; wraps at 65535 to 0.

Behaviour:
- Reset (rst high at a rising edge):
  - State goes to IDLE. out_valid, out_last, busy, fifo_rd_en are 0; out_data, the shift register, slice counter and word_count are 0.
  - A word already popped from the FIFO but not fully sent is discarded, even if reset arrives mid-operation.
- fifo_cs = !rst. fifo_rd_en is a combinational (Mealy) output of state, en, fifo_empty and out_ready.
- fifo_rd_en is never asserted while fifo_empty = 1, so there is no FIFO underflow.
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - fifo_rd_en = en && !fifo_empty.
  - If fifo_rd_en is high, go to WAIT; otherwise stay in IDLE.
- WAIT (FIFO output is valid this cycle):
  - At the edge, load the shift register with fifo_data_out and clear the slice counter to 0.
  - Go to SEND.
  - Lasts exactly one cycle; out_valid = 0.
- SEND:
  - out_valid = 1 and out_data = shift register [SLICE_WIDTH-1:0].
  - out_last = (cnt == NUM_SLICES-1).
  - If out_ready is low, hold everything: out_data, out_last and cnt are stable while stalled.
  - On handshake with cnt < NUM_SLICES-1: shift the register right by SLICE_WIDTH and increment cnt.
  - On handshake with cnt == NUM_SLICES-1:
    - Increment word_count.
    - fifo_rd_en = en && !fifo_empty in the same cycle.
    - If fifo_rd_en is high, go to WAIT; otherwise go to IDLE.
- Latency:
  - From fifo_empty falling in IDLE (en high), the first slice is valid 2 cycles later.
  - Back-to-back words leave exactly one bubble cycle (the WAIT state) between the last slice of one word and the first slice of the next.
  - Maximum throughput is NUM_SLICES slices per NUM_SLICES+1 cycles.
- en low during SEND: the current word completes normally and no further pop is issued. en has no effect in WAIT.
- fifo_data_out is sampled only in WAIT; its value in other states is ignored.
- NUM_SLICES == 1: every slice carries out_last = 1, and the counter is held at 0.
- word_count is unaffected by en and increments only on the last-slice handshake.

Test Plan:
- Reset and idle: assert rst for 2 cycles with fifo_empty = 1 and en = 1 -> all outputs 0 except fifo_cs after release; fifo_rd_en never goes high; busy = 0.
- Single word: FIFO holds 0x11223344, out_ready = 1.
  - out_data must be 0x44, 0x33, 0x22, 0x11 on consecutive cycles, with out_last only on 0x11.
  - First slice appears 2 cycles after the pop request.
  - word_count = 1; then return to IDLE.
- Backpressure: same word, out_ready toggling 1,0,0,1,0,1,1 -> each slice is held stable while stalled, the sequence stays 0x44, 0x33, 0x22, 0x11, and exactly 4 handshakes occur.
- Back-to-back: FIFO preloaded with 8 words 2**i (i = 0..7), out_ready = 1.
  - 32 slices are emitted; the first slice of each word equals (2**i) & 0xFF.
  - Exactly one out_valid = 0 cycle between words.
  - word_count = 8 and 8 fifo_rd_en pulses; fifo_rd_en is never high while fifo_empty is high.
- Enable and reset mid-word:
  - Drop en during slice 2 of word 1 with 2 words queued -> word 1 completes and no second pop occurs until en returns.
  - Assert rst during slice 3 -> next cycle out_valid = 0, state IDLE, word_count = 0, and the partial word is not re-emitted.
